// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-based arbiter for the single write port of the async FIFO.
// NUM_REQ producers share wr_en_o/wr_data_o. A grant lasts up to MAX_BURST beats,
// or HF_BURST beats while half_full_i is high. No write is issued while full_i is high.
//
// Ports:
//   wr_clk_i       write-domain clock (same as the FIFO write side)
//   wr_rst_i       synchronous active-high reset
//   req_i          per-requester write request
//   req_data_i     requester i data in [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt_o          one-hot beat-accept strobe (slice i written this cycle)
//   wr_en_o        FIFO write enable
//   wr_data_o      FIFO write data
//   full_i         FIFO full flag
//   half_full_i    FIFO half-full flag
//   owner_o        index of the current burst owner
//   owner_valid_o  a burst is in progress
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned HF_BURST   = 2,
  localparam int unsigned OwnerW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            wr_clk_i,
  input  logic                            wr_rst_i,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic                            wr_en_o,
  output logic [DATA_WIDTH-1:0]           wr_data_o,
  input  logic                            full_i,
  input  logic                            half_full_i,
  output logic [OwnerW-1:0]               owner_o,
  output logic                            owner_valid_o
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [OwnerW-1:0] owner_q, owner_d;
  logic [OwnerW-1:0] last_q, last_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [CntW-1:0]   limit;
  logic [CntW:0]     cnt_inc;
  logic [OwnerW-1:0] winner;
  logic              win_vld;
  logic              wr_en;
  logic              burst_end;

  // Limit is re-evaluated every cycle so a rising half_full shortens a running burst.
  assign limit   = half_full_i ? CntW'(HF_BURST) : CntW'(MAX_BURST);
  assign cnt_inc = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};

  // Round-robin scan starting just after the previous owner, wrapping around.
  always_comb begin
    int unsigned idx;
    logic [OwnerW-1:0] idx_w;
    winner  = '0;
    win_vld = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx   = (32'(last_q) + k) % NUM_REQ;
      idx_w = OwnerW'(idx);
      if (!win_vld && req_i[idx_w]) begin
        winner  = idx_w;
        win_vld = 1'b1;
      end
    end
  end

  // Outputs are gated by reset so nothing is written on a reset cycle.
  assign wr_en = ~wr_rst_i & (state_q == StBurst) & req_i[owner_q] & ~full_i & (cnt_q < limit);

  always_comb begin
    wr_data_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (wr_en && (owner_q == OwnerW'(i))) begin
        wr_data_o = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign gnt_o         = NUM_REQ'(wr_en) << owner_q;
  assign wr_en_o       = wr_en;
  assign owner_o       = owner_q;
  assign owner_valid_o = ~wr_rst_i & (state_q == StBurst);

  // Withdrawal, limit reached by this beat, or limit already exceeded after half_full rose.
  assign burst_end = ~req_i[owner_q]
                   | (wr_en & (cnt_inc >= {1'b0, limit}))
                   | (cnt_q >= limit);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d = StBurst;
          owner_d = winner;
          cnt_d   = '0;
        end
      end
      StBurst: begin
        if (wr_en) begin
          cnt_d = cnt_inc[CntW-1:0];
        end
        if (burst_end) begin
          state_d = StIdle;
          last_d  = owner_q;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wr_clk_i) begin
    if (wr_rst_i) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= OwnerW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: table vectors, directed corner cases and
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;

  localparam int NReq = 4;
  localparam int DW   = 32;
  localparam int MaxB = 8;
  localparam int HfB  = 2;

  logic                clk;
  logic                wr_rst;
  logic [NReq-1:0]     req;
  logic [NReq*DW-1:0]  req_data;
  logic [NReq-1:0]     gnt;
  logic                wr_en;
  logic [DW-1:0]       wr_data;
  logic                full;
  logic                half_full;
  logic [1:0]          owner;
  logic                owner_valid;

  fifo_wr_arbiter #(
    .NUM_REQ   (NReq),
    .DATA_WIDTH(DW),
    .MAX_BURST (MaxB),
    .HF_BURST  (HfB)
  ) dut (
    .wr_clk_i     (clk),
    .wr_rst_i     (wr_rst),
    .req_i        (req),
    .req_data_i   (req_data),
    .gnt_o        (gnt),
    .wr_en_o      (wr_en),
    .wr_data_o    (wr_data),
    .full_i       (full),
    .half_full_i  (half_full),
    .owner_o      (owner),
    .owner_valid_o(owner_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: busy flag, owner, previous owner, beats written in this burst.
  bit m_busy = 0;
  int m_own  = 0;
  int m_last = NReq - 1;
  int m_cnt  = 0;

  // Values sampled from the DUT in the most recent step.
  logic            s_we;
  logic [NReq-1:0] s_gnt;
  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic [1:0]      s_owner;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NReq*DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Apply one cycle of inputs, compare outputs with the model, advance past the edge.
  task automatic step(input logic r, input logic [NReq-1:0] rq, input logic f, input logic h,
                      input logic [NReq*DW-1:0] d);
    int lim;
    logic e_we;
    logic [NReq-1:0] e_g;
    logic [DW-1:0] e_d;
    logic e_v;
    wr_rst    = r;
    req       = rq;
    full      = f;
    half_full = h;
    req_data  = d;
    #4;
    s_we    = wr_en;
    s_gnt   = gnt;
    s_data  = wr_data;
    s_valid = owner_valid;
    s_owner = owner;
    lim  = h ? HfB : MaxB;
    e_we = 1'b0;
    e_g  = '0;
    e_d  = '0;
    e_v  = 1'b0;
    if (!r && m_busy) begin
      e_v  = 1'b1;
      e_we = rq[m_own] && !f && (m_cnt < lim);
      if (e_we) begin
        e_g = NReq'(1) << m_own;
        e_d = d[m_own*DW +: DW];
      end
    end
    check("wr_en", 64'(s_we), 64'(e_we));
    check("gnt", 64'(s_gnt), 64'(e_g));
    check("wr_data", 64'(s_data), 64'(e_d));
    check("owner_valid", 64'(s_valid), 64'(e_v));
    if (e_v) check("owner", 64'(s_owner), 64'(m_own));
    if (r) begin
      m_busy = 0; m_own = 0; m_last = NReq - 1; m_cnt = 0;
    end else if (!m_busy) begin
      for (int k = 1; k <= NReq; k++) begin
        int j;
        j = (m_last + k) % NReq;
        if (rq[j]) begin
          m_own = j; m_busy = 1; m_cnt = 0;
          break;
        end
      end
    end else begin
      if (e_we) m_cnt++;
      if (!rq[m_own] || m_cnt >= lim) begin
        m_busy = 0; m_last = m_own; m_cnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  rq;
    logic [31:0] d0;
    logic        e_we;
    logic [3:0]  e_gnt;
    logic [31:0] e_data;
    logic        e_valid;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int beats;
    int owners[$];
    logic pv;
    logic [3:0] rq;
    logic f, h, r;
    int exp_own[5];

    wr_rst = 1'b1; req = '0; full = 1'b0; half_full = 1'b0; req_data = '0;
    @(posedge clk);
    #1;

    // Requester 0 alone: reset, one IDLE cycle, 8 beats, IDLE, next 8 beats.
    tbl[0]  = '{1'b1, 4'b0000, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 32'h0, 1'b0, 4'b0000, 32'h0, 1'b0};
    for (int k = 0; k < 8; k++)
      tbl[2+k] = '{1'b0, 4'b0001, 32'h100 + k, 1'b1, 4'b0001, 32'h100 + k, 1'b1};
    tbl[10] = '{1'b0, 4'b0001, 32'h108, 1'b0, 4'b0000, 32'h0, 1'b0};
    for (int k = 0; k < 8; k++)
      tbl[11+k] = '{1'b0, 4'b0001, 32'h108 + k, 1'b1, 4'b0001, 32'h108 + k, 1'b1};
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].rst, tbl[i].rq, 1'b0, 1'b0, {96'h0, tbl[i].d0});
      check("tbl_wr_en", 64'(s_we), 64'(tbl[i].e_we));
      check("tbl_gnt", 64'(s_gnt), 64'(tbl[i].e_gnt));
      check("tbl_data", 64'(s_data), 64'(tbl[i].e_data));
      check("tbl_valid", 64'(s_valid), 64'(tbl[i].e_valid));
    end

    // All requesting: owners 0,1,2,3,0 in order.
    exp_own = '{0, 1, 2, 3, 0};
    step(1'b1, 4'b0000, 1'b0, 1'b0, rnd_data());
    pv = 1'b0;
    for (int i = 0; i < 60 && owners.size() < 5; i++) begin
      step(1'b0, 4'b1111, 1'b0, 1'b0, rnd_data());
      if (s_valid && !pv) owners.push_back(int'(s_owner));
      pv = s_valid;
    end
    check("rr_bursts", 64'(owners.size()), 64'd5);
    for (int i = 0; i < owners.size() && i < 5; i++) check("rr_order", 64'(owners[i]), 64'(exp_own[i]));

    // Owner 2 stalled by full at cnt=3 for 5 cycles, then the remaining 5 beats.
    step(1'b1, 4'b0000, 1'b0, 1'b0, rnd_data());
    step(1'b0, 4'b0100, 1'b0, 1'b0, rnd_data());
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 1'b0, 1'b0, rnd_data());
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0100, 1'b1, 1'b0, rnd_data());
      check("stall_wr_en", 64'(s_we), 64'd0);
    end
    beats = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'b0100, 1'b0, 1'b0, rnd_data());
      if (s_we) beats++;
    end
    check("stall_beats", 64'(beats), 64'd5);
    check("stall_idle", 64'(s_valid), 64'd0);

    // Owner 1 at cnt=4 when half_full rises: burst ends, owner 2 gets 2-beat bursts.
    step(1'b1, 4'b0000, 1'b0, 1'b0, rnd_data());
    step(1'b0, 4'b0110, 1'b0, 1'b0, rnd_data());
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0110, 1'b0, 1'b0, rnd_data());
    step(1'b0, 4'b0110, 1'b0, 1'b1, rnd_data());
    check("hf_no_gnt", 64'(s_gnt), 64'd0);
    step(1'b0, 4'b0110, 1'b0, 1'b1, rnd_data());
    check("hf_idle", 64'(s_valid), 64'd0);
    beats = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0110, 1'b0, 1'b1, rnd_data());
      if (i == 0) check("hf_next_owner", 64'(s_owner), 64'd2);
      if (s_we) beats++;
    end
    check("hf_beats", 64'(beats), 64'd2);

    // Owner 3 withdraws after 3 beats; requester 0 wins next.
    step(1'b1, 4'b0000, 1'b0, 1'b0, rnd_data());
    step(1'b0, 4'b1000, 1'b0, 1'b0, rnd_data());
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1000, 1'b0, 1'b0, rnd_data());
    step(1'b0, 4'b0001, 1'b0, 1'b0, rnd_data());
    check("wd_no_write", 64'(s_we), 64'd0);
    step(1'b0, 4'b0001, 1'b0, 1'b0, rnd_data());
    check("wd_idle", 64'(s_valid), 64'd0);
    step(1'b0, 4'b0001, 1'b0, 1'b0, rnd_data());
    check("wd_next_gnt", 64'(s_gnt), 64'b0001);

    // Reset during owner 1 cnt=5; requester 0 is granted first afterwards.
    step(1'b1, 4'b0000, 1'b0, 1'b0, rnd_data());
    step(1'b0, 4'b0010, 1'b0, 1'b0, rnd_data());
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0010, 1'b0, 1'b0, rnd_data());
    step(1'b1, 4'b0011, 1'b0, 1'b0, rnd_data());
    check("rst_wr_en", 64'(s_we), 64'd0);
    check("rst_valid", 64'(s_valid), 64'd0);
    step(1'b0, 4'b0011, 1'b0, 1'b0, rnd_data());
    check("rst_after_valid", 64'(s_valid), 64'd0);
    step(1'b0, 4'b0011, 1'b0, 1'b0, rnd_data());
    check("rst_first_gnt", 64'(s_gnt), 64'b0001);

    // Randomized traffic against the model.
    rq = 4'b0000; f = 1'b0; h = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < NReq; b++) if ($urandom_range(7) == 0) rq[b] = ~rq[b];
      f = ($urandom_range(3) == 0);
      if ($urandom_range(15) == 0) h = ~h;
      r = ($urandom_range(199) == 0);
      step(r, rq, f, h, rnd_data());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
